// File: rtl/id_pkg.sv
// Shared decode constants for id_stage: MIPS opcodes, instruction field
// positions and the helper that tells whether an instruction reads rt.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int SH_MSB  = 10;
   localparam int SH_LSB  = 6;
   localparam int FN_MSB  = 5;
   localparam int FN_LSB  = 0;
   localparam int IMM_MSB = 15;
   localparam int TGT_MSB = 25;

   // Instructions whose rt field is a source operand (not a destination).
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/id_reg_file.sv
// Register file for the decode stage: two combinational read ports, one
// synchronous write port, asynchronous clear, register 0 hard-wired to zero.
module id_reg_file #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [REG_ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0]     rdata_a,
   input  logic [REG_ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0]     rdata_b
);

   localparam int NUM_REGS = 2**REG_ADDR_W;

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != '0)) regs_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= '0;
      else        regs_q <= regs_d;
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: one-slot output register, register-file read,
// load-use bubble insertion and flush. Define ID_WB_BYPASS_EN to forward a
// same-cycle writeback into the captured operands.
module id_stage
   import id_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [DATA_W-1:0]      in_next_pc,
   input  logic                   flush,
   input  logic                   wb_en,
   input  logic [REG_ADDR_W-1:0]  wb_addr,
   input  logic [DATA_W-1:0]      wb_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [5:0]             out_opcode,
   output logic [5:0]             out_funct,
   output logic [4:0]             out_shamt,
   output logic [REG_ADDR_W-1:0]  out_rs,
   output logic [REG_ADDR_W-1:0]  out_rt,
   output logic [REG_ADDR_W-1:0]  out_rd,
   output logic [DATA_W-1:0]      out_rs_data,
   output logic [DATA_W-1:0]      out_rt_data,
   output logic [DATA_W-1:0]      out_imm,
   output logic [DATA_W-1:0]      out_jump_addr,
   output logic [STALL_CNT_W-1:0] stall_count
);

   logic [5:0]            in_op;
   logic [REG_ADDR_W-1:0] in_rs, in_rt, in_rd;
   logic [DATA_W-1:0]     rf_rs, rf_rt, rs_val, rt_val, imm_ext, jump_addr;
   logic                  load_use, accept;
   logic                  unused_pc;

   assign in_op = in_instr[OPC_MSB:OPC_LSB];
   assign in_rs = REG_ADDR_W'(in_instr[RS_MSB:RS_LSB]);
   assign in_rt = REG_ADDR_W'(in_instr[RT_MSB:RT_LSB]);
   assign in_rd = REG_ADDR_W'(in_instr[RD_MSB:RD_LSB]);
   assign unused_pc = ^in_next_pc[27:0];

   id_reg_file #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (in_rs),
      .rdata_a (rf_rs),
      .raddr_b (in_rt),
      .rdata_b (rf_rt)
   );

`ifdef ID_WB_BYPASS_EN
   assign rs_val = (wb_en && (wb_addr != '0) && (wb_addr == in_rs)) ? wb_data : rf_rs;
   assign rt_val = (wb_en && (wb_addr != '0) && (wb_addr == in_rt)) ? wb_data : rf_rt;
`else
   assign rs_val = rf_rs;
   assign rt_val = rf_rt;
`endif

   // Logical immediates are zero-extended; everything else sign-extends.
   assign imm_ext = ((in_op == OP_ANDI) || (in_op == OP_ORI) || (in_op == OP_XORI))
                    ? {{(DATA_W-16){1'b0}}, in_instr[IMM_MSB:0]}
                    : {{(DATA_W-16){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:0]};
   assign jump_addr = {in_next_pc[DATA_W-1:28], in_instr[TGT_MSB:0], 2'b00};

   logic                   out_valid_q, out_valid_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic [5:0]             opcode_q, opcode_d, funct_q, funct_d;
   logic [4:0]             shamt_q, shamt_d;
   logic [REG_ADDR_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [DATA_W-1:0]      rs_data_q, rs_data_d, rt_data_q, rt_data_d;
   logic [DATA_W-1:0]      imm_q, imm_d, jump_q, jump_d;

   assign load_use = in_valid && out_valid_q && (opcode_q == OP_LW) && (rt_q != '0) &&
                     ((in_rs == rt_q) || (uses_rt(in_op) && (in_rt == rt_q)));
   assign in_ready = flush || ((!out_valid_q || out_ready) && !load_use);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      stall_d     = stall_q;
      opcode_d    = opcode_q;
      funct_d     = funct_q;
      shamt_d     = shamt_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      imm_d       = imm_q;
      jump_d      = jump_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         opcode_d    = in_op;
         funct_d     = in_instr[FN_MSB:FN_LSB];
         shamt_d     = in_instr[SH_MSB:SH_LSB];
         rs_d        = in_rs;
         rt_d        = in_rt;
         rd_d        = in_rd;
         rs_data_d   = rs_val;
         rt_data_d   = rt_val;
         imm_d       = imm_ext;
         jump_d      = jump_addr;
      end else if (out_ready) begin
         // Slot drains; if the consumer was blocked by a load, that is the bubble.
         out_valid_d = 1'b0;
         if (load_use && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         stall_q     <= '0;
         opcode_q    <= '0;
         funct_q     <= '0;
         shamt_q     <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         jump_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         stall_q     <= stall_d;
         opcode_q    <= opcode_d;
         funct_q     <= funct_d;
         shamt_q     <= shamt_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         jump_q      <= jump_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign stall_count   = stall_q;
   assign out_opcode    = opcode_q;
   assign out_funct     = funct_q;
   assign out_shamt     = shamt_q;
   assign out_rs        = rs_q;
   assign out_rt        = rt_q;
   assign out_rd        = rd_q;
   assign out_rs_data   = rs_data_q;
   assign out_rt_data   = rt_data_q;
   assign out_imm       = imm_q;
   assign out_jump_addr = jump_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed pins plus randomized traffic, checked every
// cycle against a behavioural slot/register-file model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
   logic [31:0] in_instr, in_next_pc, wb_data;
   logic [4:0]  wb_addr;
   logic [5:0]  out_opcode, out_funct;
   logic [4:0]  out_shamt, out_rs, out_rt, out_rd;
   logic [31:0] out_rs_data, out_rt_data, out_imm, out_jump_addr;
   logic [15:0] stall_count;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_next_pc(in_next_pc), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_funct(out_funct), .out_shamt(out_shamt), .out_rs(out_rs),
      .out_rt(out_rt), .out_rd(out_rd), .out_rs_data(out_rs_data),
      .out_rt_data(out_rt_data), .out_imm(out_imm),
      .out_jump_addr(out_jump_addr), .stall_count(stall_count)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: one instruction slot and an array of registers.
   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [31:0] m_instr, m_rsd, m_rtd, m_imm, m_jmp;
   int          m_stall;

   function automatic logic [31:0] rd_reg(input logic [4:0] a);
      logic [31:0] v;
      v = m_regs[a];
`ifdef ID_WB_BYPASS_EN
      if (wb_en && wb_addr != 0 && wb_addr == a) v = wb_data;
`endif
      return v;
   endfunction

   always @(negedge clk) begin
      logic        hz, rdy;
      logic [5:0]  op, lop;
      logic [4:0]  rs, rt, lrt;
      n_vec++;
      if (!rst_n) begin
         foreach (m_regs[i]) m_regs[i] = 32'h0;
         m_valid = 1'b0; m_instr = 32'h0; m_rsd = 32'h0; m_rtd = 32'h0;
         m_imm = 32'h0; m_jmp = 32'h0; m_stall = 0;
      end
      chk("out_valid",   64'(out_valid),     64'(m_valid));
      chk("stall_count", 64'(stall_count),   64'(m_stall));
      chk("opcode",      64'(out_opcode),    64'(m_instr[31:26]));
      chk("funct",       64'(out_funct),     64'(m_instr[5:0]));
      chk("shamt",       64'(out_shamt),     64'(m_instr[10:6]));
      chk("rs",          64'(out_rs),        64'(m_instr[25:21]));
      chk("rt",          64'(out_rt),        64'(m_instr[20:16]));
      chk("rd",          64'(out_rd),        64'(m_instr[15:11]));
      chk("rs_data",     64'(out_rs_data),   64'(m_rsd));
      chk("rt_data",     64'(out_rt_data),   64'(m_rtd));
      chk("imm",         64'(out_imm),       64'(m_imm));
      chk("jump_addr",   64'(out_jump_addr), 64'(m_jmp));
      if (rst_n) begin
         op  = in_instr[31:26]; rs = in_instr[25:21]; rt = in_instr[20:16];
         lop = m_instr[31:26];  lrt = m_instr[20:16];
         hz  = in_valid && m_valid && lop == 6'h23 && lrt != 0 &&
               (rs == lrt || (op inside {6'h00, 6'h04, 6'h05, 6'h2B} && rt == lrt));
         rdy = flush || ((!m_valid || out_ready) && !hz);
         chk("in_ready", 64'(in_ready), 64'(rdy));
         if (flush) begin
            m_valid = 1'b0;
         end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_instr = in_instr;
            m_rsd   = rd_reg(rs);
            m_rtd   = rd_reg(rt);
            m_imm   = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, in_instr[15:0]}
                                                       : 32'($signed(in_instr[15:0]));
            m_jmp   = (in_next_pc & 32'hF000_0000) | (in_instr & 32'h03FF_FFFF) * 4;
         end else if (out_ready) begin
            if (m_valid && hz && m_stall < 65535) m_stall++;
            m_valid = 1'b0;
         end
         if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      end
   end

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
      in_valid = v; in_instr = ins; in_next_pc = pc; out_ready = ordy; flush = fl;
      wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0]  ops [9];
      logic [31:0] ins;
      ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
      rst_n = 1'b0;
      drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
      repeat (3) step();
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset stall", 64'(stall_count), 64'(0));
      rst_n = 1'b1;

      // Streaming ADDI words, 1-cycle latency.
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h2000_0000 | ((i + 1) << 16) | (5 + i), 32'h100, 1, 0, 0, 5'd0, 32'h0);
         step();
         chk("stream valid", 64'(out_valid), 64'(1));
         chk("stream imm", 64'(out_imm), 64'(5 + i));
      end
      drive(0, 32'h0, 32'h100, 1, 0, 0, 5'd0, 32'h0);
      step();

      // Load-use: exactly one bubble.
      drive(1, 32'h8C03_0000, 32'h200, 1, 0, 0, 5'd0, 32'h0);
      step();
      drive(1, 32'h0061_2020, 32'h204, 1, 0, 0, 5'd0, 32'h0);
      chk("lu in_ready", 64'(in_ready), 64'(0));
      step();
      chk("lu bubble", 64'(out_valid), 64'(0));
      chk("lu stall", 64'(stall_count), 64'(1));
      step();
      chk("lu add valid", 64'(out_valid), 64'(1));
      chk("lu add rd", 64'(out_rd), 64'(4));
      drive(1, 32'h8C03_0000, 32'h208, 1, 0, 0, 5'd0, 32'h0);
      step();
      drive(1, 32'h0041_2020, 32'h20C, 1, 0, 0, 5'd0, 32'h0);
      chk("nolu in_ready", 64'(in_ready), 64'(1));
      step();
      chk("nolu valid", 64'(out_valid), 64'(1));
      chk("nolu stall", 64'(stall_count), 64'(1));

      // Backpressure then flush.
      drive(1, 32'h3405_8000, 32'h300, 1, 0, 0, 5'd0, 32'h0);
      step();
      chk("ori imm", 64'(out_imm), 64'(32'h0000_8000));
      drive(1, 32'h2006_8000, 32'h304, 0, 0, 0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp valid", 64'(out_valid), 64'(1));
         chk("bp imm", 64'(out_imm), 64'(32'h0000_8000));
         chk("bp in_ready", 64'(in_ready), 64'(0));
      end
      drive(1, 32'h2006_8000, 32'h304, 0, 1, 0, 5'd0, 32'h0);
      chk("flush in_ready", 64'(in_ready), 64'(1));
      step();
      chk("flush valid", 64'(out_valid), 64'(0));
      drive(0, 32'h0, 32'h304, 1, 0, 0, 5'd0, 32'h0);
      step();
      chk("flush dropped", 64'(out_valid), 64'(0));
      chk("flush held imm", 64'(out_imm), 64'(32'h0000_8000));
      drive(1, 32'h2006_8000, 32'h304, 1, 0, 0, 5'd0, 32'h0);
      step();
      chk("addi imm", 64'(out_imm), 64'(32'hFFFF_8000));
      drive(1, 32'h0800_0010, 32'h4000_0004, 1, 0, 0, 5'd0, 32'h0);
      step();
      chk("jump addr", 64'(out_jump_addr), 64'(32'h4000_0040));

      // Same-cycle writeback vs. capture.
      drive(0, 32'h0, 32'h400, 1, 0, 1, 5'd3, 32'h1111_1111);
      step();
      drive(1, 32'h0061_2020, 32'h404, 1, 0, 1, 5'd3, 32'hDEAD_BEEF);
      step();
`ifdef ID_WB_BYPASS_EN
      chk("bypass rs", 64'(out_rs_data), 64'(32'hDEAD_BEEF));
`else
      chk("stale rs", 64'(out_rs_data), 64'(32'h1111_1111));
`endif
      drive(1, 32'h0061_2020, 32'h408, 1, 0, 1, 5'd0, 32'h5555_5555);
      step();
      chk("wb visible", 64'(out_rs_data), 64'(32'hDEAD_BEEF));
      drive(1, 32'h0000_2020, 32'h40C, 1, 0, 0, 5'd0, 32'h0);
      step();
      chk("r0 rs", 64'(out_rs_data), 64'(0));
      chk("r0 rt", 64'(out_rt_data), 64'(0));

      // Random traffic on a small register set to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         ins = $urandom;
         ins[31:26] = ops[$urandom_range(0, 8)];
         ins[25:21] = 5'($urandom_range(0, 3));
         ins[20:16] = 5'($urandom_range(0, 3));
         drive($urandom_range(0, 9) < 8, ins, $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
         step();
      end

      // Mid-stream reset clears state and the register file.
      drive(0, 32'h0, 32'h500, 1, 0, 1, 5'd5, 32'h0000_ABCD);
      step();
      drive(1, 32'h00A0_0000, 32'h504, 1, 0, 0, 5'd0, 32'h0);
      step();
      chk("r5 written", 64'(out_rs_data), 64'(32'h0000_ABCD));
      rst_n = 1'b0;
      #1;
      chk("mid reset valid", 64'(out_valid), 64'(0));
      chk("mid reset stall", 64'(stall_count), 64'(0));
      step();
      rst_n = 1'b1;
      drive(1, 32'h00A0_0000, 32'h508, 1, 0, 0, 5'd0, 32'h0);
      step();
      chk("r5 cleared", 64'(out_rs_data), 64'(0));
      chk("post reset valid", 64'(out_valid), 64'(1));
      drive(0, 32'h0, 32'h50C, 1, 0, 0, 5'd0, 32'h0);
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode pipeline stage for the MIPS core, sitting between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and extracts the fields. It reads operands from an internal register file with writeback bypass, extends the immediate and forms the jump target. It inserts exactly one bubble on a load-use hazard and supports flush on a redirect.

## Interface
- DATA_W, 32: register and PC width; must be ≥ 32.
- REG_ADDR_W, 5: register index width; NUM_REGS = 2**REG_ADDR_W.
- STALL_CNT_W, 16: width of the saturating stall counter.
- clk  in  1  clock; one clock domain only.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid / in_ready  in / out  1  upstream handshake.
- in_instr  in  32  instruction word.
- in_next_pc  in  DATA_W  PC+4 of in_instr.
- flush  in  1  kills the held output and the offered input.
- wb_en, wb_addr, wb_data  in  1 / REG_ADDR_W / DATA_W  writeback port.
- out_valid / out_ready  out / in  1  downstream handshake.
- out_opcode, out_funct  out  6  instr[31:26], instr[5:0].
- out_shamt  out  5  instr[10:6].
- out_rs, out_rt, out_rd  out  REG_ADDR_W  register indices, zero-extended from 5 bits.
- out_rs_data, out_rt_data  out  DATA_W  operand values.
- out_imm  out  DATA_W  extended immediate.
- out_jump_addr  out  DATA_W  {in_next_pc[DATA_W-1:28], instr[25:0], 2'b00}.
- stall_count  out  STALL_CNT_W  load-use bubbles inserted; saturates at all-ones.

## Operation
- Output register is the single pipeline slot.
  - Accept when in_valid & in_ready.
  - in_ready = flush | ((~out_valid | out_ready) & ~load_use).
- Load-use detection:
  - load_use = in_valid & out_valid & out_opcode==OP_LW & out_rt!=0 & (in_rs==out_rt | (uses_rt(in) & in_rt==out_rt)).
  - uses_rt is true for opcodes RTYPE, BEQ, BNE and SW.
- When load_use & out_ready: the load leaves, out_valid<=0 (bubble), and stall_count increments. Input is held, so the next cycle accepts it: exactly one bubble.
- When load_use & ~out_ready: hold everything. This does not count as a stall.
- flush has top priority:
  - Next edge: out_valid<=0.
  - The offered input is consumed and discarded.
  - stall_count is unchanged.
- Immediate extension:
  - Zero-extend for ANDI, ORI and XORI.
  - Sign-extend from bit 15 otherwise.
- Register file:
  - Written at posedge clk when wb_en & wb_addr!=0.
  - Register 0 always reads 0.
  - Reads are combinational and captured into the output register on accept.
- A simultaneous accept and writeback to a read register is governed by ID_WB_BYPASS_EN.
- All out_* data fields update only on accept. They hold while out_valid & ~out_ready.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle when out_ready is held high and there are no hazards.
- Reset (asynchronous assert, synchronous-safe deassert):
  - out_valid=0, stall_count=0.
  - All out_* data fields 0.
  - All registers 0.
- in_ready is combinational from in_valid, in_instr, out_ready, flush and the slot state.
- A writeback is visible to reads in the cycle after its edge, regardless of the macro.
- Reset mid-operation drops the held instruction; no partial state survives.

## Configuration
- ID_WB_BYPASS_EN defined:
  - If wb_en & wb_addr!=0 & wb_addr matches rs (or rt) on the accepting cycle, wb_data is captured instead of the stale register value.
- ID_WB_BYPASS_EN undefined:
  - The stale (pre-write) value is captured.
  - Execute-side forwarding must cover this case.

## Structure
- Package id_pkg holds:
  - Opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03, OP_BEQ=6'h04, OP_BNE=6'h05, OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_XORI=6'h0E, OP_LW=6'h23, OP_SW=6'h2B.
  - Field bit-position constants.
  - The uses_rt function.
- One sub-module, id_reg_file, parametrised by DATA_W and REG_ADDR_W. It has 2 combinational read ports, 1 synchronous write port, asynchronous clear, and hard-wired r0.
- Hazard, extension and handshake logic live in id_stage.

## Test plan
- Reset: pulse rst_n low mid-stream -> out_valid=0, stall_count=0, and reading r5 returns 0.
- Streaming: ADDI-style words 0x2001_0005, 0x2002_0006, … with out_ready=1 -> one output per cycle, 1-cycle latency, and out_imm=5, 6, ….
- Load-use: LW r3 (0x8C03_0000) then ADD r4,r3,r1 (0x0061_2020) -> exactly one bubble between them and stall_count=1. The same sequence with ADD r4,r2,r1 gives no bubble.
- Backpressure plus flush:
  - out_ready=0 for 3 cycles -> outputs stable and in_ready=0.
  - flush with in_valid=1 -> next cycle out_valid=0 and the input is dropped.
- Extension and jump:
  - ORI with imm 0x8000 -> out_imm=0x0000_8000.
  - ADDI with 0x8000 -> 0xFFFF_8000.
  - J with 0x0800_0010 at next_pc 0x4000_0004 -> out_jump_addr=0x4000_0040.
- Bypass: wb_en=1, wb_addr=3, wb_data=0xDEAD_BEEF in the same cycle as accepting an instruction reading r3 -> 0xDEAD_BEEF with ID_WB_BYPASS_EN, the old value without it. A write to r0 is ignored.
